// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths, MEM-stage FSM states and the MEM/WB bundle
//               for the 5-stage MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // MEM-stage access sequencer states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // Contents of the MEM/WB pipeline register
    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem_data;
        logic [REG_W-1:0]  rd;
    } mem_wb_t;

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register. A bubble clears the write-back
//               controls; load data is captured only on completing reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bubble_i,
    input  logic                        load_mem_i,
    input  logic                        reg_write_i,
    input  logic                        mem_to_reg_i,
    input  logic [mips_pkg::DATA_W-1:0] alu_i,
    input  logic [mips_pkg::DATA_W-1:0] mem_data_i,
    input  logic [mips_pkg::REG_W-1:0]  rd_i,
    output logic                        reg_write_o,
    output logic                        mem_to_reg_o,
    output logic [mips_pkg::DATA_W-1:0] alu_o,
    output logic [mips_pkg::DATA_W-1:0] mem_data_o,
    output logic [mips_pkg::REG_W-1:0]  rd_o
);
    import mips_pkg::*;

    mem_wb_t wb_d;
    mem_wb_t wb_q;

    // Next MEM/WB contents: ALU result and destination always follow the
    // inputs, controls are squashed on a bubble, load data holds unless a
    // read completes this cycle.
    always_comb begin
        wb_d     = wb_q;
        wb_d.alu = alu_i;
        wb_d.rd  = rd_i;
        if (bubble_i) begin
            wb_d.reg_write  = 1'b0;
            wb_d.mem_to_reg = 1'b0;
        end else begin
            wb_d.reg_write  = reg_write_i;
            wb_d.mem_to_reg = mem_to_reg_i;
        end
        if (load_mem_i) begin
            wb_d.mem_data = mem_data_i;
        end
    end

    // Register update with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign reg_write_o  = wb_q.reg_write;
    assign mem_to_reg_o = wb_q.mem_to_reg;
    assign alu_o        = wb_q.alu;
    assign mem_data_o   = wb_q.mem_data;
    assign rd_o         = wb_q.rd;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM stage of the MIPS pipeline. Issues data-memory loads and
//               stores over a req/ack handshake, stalls upstream while the
//               memory is busy and feeds the MEM/WB register.
//               Optional macro MEM_TIMEOUT_EN: abandon an access after
//               TIMEOUT_CYC wait cycles without ack and pulse err_o.
//               DATA_W / REG_W must match the mips_pkg values.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int DATA_W      = mips_pkg::DATA_W,
    parameter int REG_W       = mips_pkg::REG_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [DATA_W-1:0] ALU_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic [REG_W-1:0]  rd_i,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              err_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALU_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [REG_W-1:0]  rd_o
);
    import mips_pkg::*;

    mem_state_e state_d;
    mem_state_e state_q;
    logic       misalign_d;
    logic       misalign_q;
    logic       req_w;
    logic       stall_w;
    logic       bubble_w;
    logic       load_mem_w;
    logic       op_w;
    logic       aligned_w;
    logic       reg_write_w;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             err_d;
    logic             err_q;
`else
    logic [31:0]      timeout_unused;
    assign timeout_unused = 32'(TIMEOUT_CYC);
`endif

    assign op_w      = MemRead_i | MemWrite_i;
    assign aligned_w = (ALU_i[1:0] == 2'b00);

    // Stores never write the register file, whatever decode asked for
    assign reg_write_w = RegWrite_i & ~MemWrite_i;

    // Access sequencing: request, stall, bubble and completion decisions
    always_comb begin
        state_d    = state_q;
        req_w      = 1'b0;
        stall_w    = 1'b0;
        bubble_w   = 1'b0;
        load_mem_w = 1'b0;
        misalign_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (op_w) begin
                    if (aligned_w) begin
                        req_w = 1'b1;
                        if (dmem_ack) begin
                            // zero-wait completion, behaves like a plain register
                            load_mem_w = ~MemWrite_i;
                        end else begin
                            stall_w  = 1'b1;
                            bubble_w = 1'b1;
                            state_d  = WAIT;
`ifdef MEM_TIMEOUT_EN
                            cnt_d    = '0;
`endif
                        end
                    end else begin
                        // misaligned: suppress the access, drop the instruction
                        misalign_d = 1'b1;
                        bubble_w   = 1'b1;
                    end
                end
            end
            WAIT: begin
                req_w = 1'b1;
                if (dmem_ack) begin
                    load_mem_w = ~MemWrite_i;
                    state_d    = IDLE;
                end else begin
`ifdef MEM_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                        // give up: release the pipeline with a bubble
                        req_w    = 1'b0;
                        bubble_w = 1'b1;
                        err_d    = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        stall_w  = 1'b1;
                        bubble_w = 1'b1;
                    end
`else
                    stall_w  = 1'b1;
                    bubble_w = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait-cycle counter and timeout pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Handshake and stall are masked by reset so they drop without a clock
    assign dmem_req   = rst_n & req_w;
    assign stall_o    = rst_n & stall_w;
    assign dmem_we    = MemWrite_i;
    assign dmem_addr  = ALU_i;
    assign dmem_wdata = rt_i;
    assign misalign_o = misalign_q;

    mem_wb_reg u_mem_wb_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .bubble_i     (bubble_w),
        .load_mem_i   (load_mem_w),
        .reg_write_i  (reg_write_w),
        .mem_to_reg_i (MemtoReg_i),
        .alu_i        (ALU_i),
        .mem_data_i   (dmem_rdata),
        .rd_i         (rd_i),
        .reg_write_o  (RegWrite_o),
        .mem_to_reg_o (MemtoReg_o),
        .alu_o        (ALU_o),
        .mem_data_o   (mem_data_o),
        .rd_o         (rd_o)
    );

endmodule
`default_nettype wire
